// File: rtl/ula_ctrl.sv
// 8-bit ALU with accumulator and a valid/ready handshake; one result held until taken.
// Define ULA_FLAGS_EN to build the {n, c, z} flag logic; otherwise flags read 000.
module ula_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] sel,
  input  logic       use_acc,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       wr_acc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out,
  output logic [2:0] flags,
  output logic       err,
  output logic [7:0] acc
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state_q, state_d;
  logic [7:0] out_q, out_d;
  logic       err_q, err_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] opA;
  logic [7:0] res;
  logic       illegal;
`ifdef ULA_FLAGS_EN
  logic       carry;
  logic [2:0] flags_q, flags_d;
`endif

  // Operand a is the accumulator value from before this edge's write-back.
  always_comb begin
    opA     = use_acc ? acc_q : a_in;
    res     = 8'd0;
    illegal = 1'b0;
`ifdef ULA_FLAGS_EN
    carry   = 1'b0;
`endif
    case (sel)
      3'b000: begin
`ifdef ULA_FLAGS_EN
        {carry, res} = {1'b0, opA} + {1'b0, b_in};
`else
        res = opA + b_in;
`endif
      end
      3'b001: begin
`ifdef ULA_FLAGS_EN
        {carry, res} = {1'b0, opA} - {1'b0, b_in};
`else
        res = opA - b_in;
`endif
      end
      3'b010:  res = opA & b_in;
      3'b011:  res = opA | b_in;
      3'b100:  res = opA ^ b_in;
      3'b101:  res = ~opA;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = err_q;
    acc_d   = acc_q;
`ifdef ULA_FLAGS_EN
    flags_d = flags_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = HOLD;
          out_d   = illegal ? 8'd0 : res;
          err_d   = illegal;
          if (wr_acc && !illegal) acc_d = res;
`ifdef ULA_FLAGS_EN
          flags_d = illegal ? 3'b000 : {res[7], carry, (res == 8'd0)};
`endif
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= 8'd0;
      err_q   <= 1'b0;
      acc_q   <= 8'd0;
`ifdef ULA_FLAGS_EN
      flags_q <= 3'b000;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
`ifdef ULA_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign out       = out_q;
  assign err       = err_q;
  assign acc       = acc_q;
`ifdef ULA_FLAGS_EN
  assign flags     = flags_q;
`else
  assign flags     = 3'b000;
`endif

endmodule

// File: tb/tb_ula_ctrl.sv
// Directed self-checking bench for ula_ctrl; flag expectations follow ULA_FLAGS_EN.
module tb_ula_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic       use_acc;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       wr_acc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [2:0] flags;
  logic       err;
  logic [7:0] acc;

  int checks = 0;
  int errors = 0;

  ula_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .use_acc(use_acc), .a_in(a_in), .b_in(b_in), .wr_acc(wr_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .flags(flags),
    .err(err), .acc(acc)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] expF(input logic [2:0] f);
`ifdef ULA_FLAGS_EN
    return f;
`else
    return 3'b000;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one command, check the held result, then let the consumer take it.
  task automatic applyStimulus(input string tag, input logic [2:0] s, input logic ua,
                               input logic [7:0] a, input logic [7:0] b, input logic wa,
                               input logic [7:0] eOut, input logic [2:0] eFlags,
                               input logic eErr, input logic [7:0] eAcc);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput({tag, "_timeout"}, 16'(in_ready), 16'd1);
    sel = s; use_acc = ua; a_in = a; b_in = b; wr_acc = wa; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, "_valid"}, 16'(out_valid), 16'd1);
    checkOutput({tag, "_out"},   16'(out),       16'(eOut));
    checkOutput({tag, "_flags"}, 16'(flags),     16'(expF(eFlags)));
    checkOutput({tag, "_err"},   16'(err),       16'(eErr));
    checkOutput({tag, "_acc"},   16'(acc),       16'(eAcc));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_idle"}, 16'({out_valid, in_ready}), 16'b01);
  endtask

  task automatic runBasicOps();
    applyStimulus("add", 3'b000, 1'b0, 8'd5, 8'd3, 1'b0, 8'd8,   3'b000, 1'b0, 8'd0);
    applyStimulus("sub", 3'b001, 1'b0, 8'd5, 8'd3, 1'b0, 8'd2,   3'b000, 1'b0, 8'd0);
    applyStimulus("and", 3'b010, 1'b0, 8'd5, 8'd3, 1'b0, 8'd1,   3'b000, 1'b0, 8'd0);
    applyStimulus("or",  3'b011, 1'b0, 8'd5, 8'd3, 1'b0, 8'd7,   3'b000, 1'b0, 8'd0);
    applyStimulus("xor", 3'b100, 1'b0, 8'd5, 8'd3, 1'b0, 8'd6,   3'b000, 1'b0, 8'd0);
    applyStimulus("not", 3'b101, 1'b0, 8'd5, 8'd3, 1'b0, 8'd250, 3'b100, 1'b0, 8'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 3'b000; use_acc = 1'b0;
    a_in = 8'd0; b_in = 8'd0; wr_acc = 1'b0; out_ready = 1'b0;
    #1;
    checkOutput("rst_hs",  16'({in_ready, out_valid}), 16'b10);
    checkOutput("rst_out", 16'({out, flags, err}), 16'd0);
    checkOutput("rst_acc", 16'(acc), 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    runBasicOps();

    applyStimulus("borrow", 3'b001, 1'b0, 8'd3,   8'd5, 1'b0, 8'hFE, 3'b110, 1'b0, 8'd0);
    applyStimulus("carry",  3'b000, 1'b0, 8'hFF,  8'd1, 1'b0, 8'h00, 3'b011, 1'b0, 8'd0);

    applyStimulus("acc_add", 3'b000, 1'b0, 8'd5, 8'd3, 1'b1, 8'd8, 3'b000, 1'b0, 8'd8);
    applyStimulus("acc_sub", 3'b001, 1'b1, 8'd99, 8'd3, 1'b1, 8'd5, 3'b000, 1'b0, 8'd5);
    applyStimulus("acc_set", 3'b000, 1'b0, 8'd4, 8'd4, 1'b1, 8'd8, 3'b000, 1'b0, 8'd8);
    applyStimulus("illegal", 3'b111, 1'b0, 8'd5, 8'd3, 1'b1, 8'd0, 3'b000, 1'b1, 8'd8);
    applyStimulus("ill110",  3'b110, 1'b1, 8'd5, 8'd3, 1'b1, 8'd0, 3'b000, 1'b1, 8'd8);

    // Backpressure: first result held four cycles while a second command waits.
    @(negedge clk);
    sel = 3'b100; use_acc = 1'b0; a_in = 8'h0F; b_in = 8'hF0; wr_acc = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    sel = 3'b000; a_in = 8'd10; b_in = 8'd20;
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp_hs",  16'({out_valid, in_ready}), 16'b10);
      checkOutput("bp_out", 16'(out), 16'hFF);
      checkOutput("bp_flg", 16'(flags), 16'(expF(3'b100)));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_xfer", 16'({out_valid, in_ready}), 16'b01);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_2nd_v",   16'(out_valid), 16'd1);
    checkOutput("bp_2nd_out", 16'(out), 16'd30);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset pulse between edges while a result is held.
    @(negedge clk);
    sel = 3'b000; a_in = 8'd1; b_in = 8'd1; wr_acc = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("pre_rst_acc", 16'(acc), 16'd2);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_hs",  16'({out_valid, in_ready}), 16'b01);
    checkOutput("async_acc", 16'(acc), 16'd0);
    checkOutput("async_out", 16'({out, flags, err}), 16'd0);
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_hold", 16'({out_valid, in_ready}), 16'b01);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst", 16'({out_valid, in_ready}), 16'b01);
    checkOutput("post_acc", 16'(acc), 16'd0);

    runBasicOps();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ula_ctrl.md
ULA_CTRL -- requirements
Module: ula_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, ports listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  command present.
REQ-005 in_ready  output  1  block can accept a command.
REQ-006 sel  input  3  op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a; 110/111 illegal.
REQ-007 use_acc  input  1  1: operand a = accumulator; 0: operand a = a_in.
REQ-008 a_in  input  8  operand a when use_acc=0.
REQ-009 b_in  input  8  operand b.
REQ-010 wr_acc  input  1  1: write result into accumulator.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out  output  8  registered result.
REQ-014 flags  output  3  {n, c, z} for out.
REQ-015 err  output  1  result came from an illegal sel.
REQ-016 acc  output  8  current accumulator value.

Function
REQ-017 Two states SHALL exist: IDLE (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-018 IDLE with in_valid=1 SHALL capture the command and compute it on that edge, go to HOLD; out, flags and err valid the next cycle (latency 1).
REQ-019 HOLD SHALL keep out/flags/err stable until out_valid && out_ready, then return to IDLE; no new command is accepted in the cycle of that transfer.
REQ-020 Arithmetic SHALL be 8-bit, wrapping: add = a+b, carry-in 0; sub = a-b, borrow-in 0.
REQ-021 c SHALL be the carry-out for add, the borrow (a<b unsigned) for sub, 0 for logic ops.
REQ-022 z SHALL be 1 iff out==0; n SHALL equal out[7].
REQ-023 sel 110/111 SHALL produce out=0, flags=000, err=1, no accumulator write regardless of wr_acc.
REQ-024 With wr_acc=1 and legal sel, acc SHALL update on the same edge the command is accepted; acc reads the new value in HOLD.
REQ-025 use_acc=1 SHALL use the accumulator value before that edge's update.
REQ-026 in_valid in HOLD SHALL be ignored; the upstream must hold the command until in_ready.

Reset
REQ-027 Reset SHALL force IDLE, out=0, flags=000, err=0, acc=0, out_valid=0, in_ready=1 immediately, without waiting for clk.
REQ-028 Reset in HOLD SHALL drop the pending result; a command on the reset-release edge SHALL not be accepted.

Configuration
REQ-029 Macro ULA_FLAGS_EN defined: flags SHALL behave as REQ-021/022.
REQ-030 ULA_FLAGS_EN undefined: flags SHALL be tied to 000 and the flag logic omitted; out, err, acc and handshake are unaffected.

Verification
REQ-031 a_in=5, b_in=3, sel 000/001/010/011/100/101 in turn, out_ready=1 -> out 8, 2, 1, 7, 6, 250; flags 000, 000, 000, 000, 000, 100.
REQ-032 a_in=3, b_in=5, sel=001 -> out=0xFE, flags n=1 c=1 z=0; a_in=0xFF, b_in=1, sel=000 -> out=0, c=1, z=1.
REQ-033 Accumulate: wr_acc=1: use_acc=0, a_in=5, b_in=3, add -> acc=8; then use_acc=1, b_in=3, sub -> out=5, acc=5.
REQ-034 Backpressure: out_ready=0 for 4 cycles after acceptance -> out_valid=1, out stable, in_ready=0; a second command with in_valid held is accepted only the cycle after out_ready=1.
REQ-035 sel=111, wr_acc=1, acc=8 -> err=1, out=0, acc stays 8.
REQ-036 rst pulse in HOLD, between clock edges -> out_valid=0, acc=0 at once, IDLE after release; repeat REQ-031 with ULA_FLAGS_EN undefined -> flags always 000.
